aes_enc_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 53 +++++
 rtl/aes_sbox.sv | 31 +++
 rtl/aes_enc_iter.sv | 123 ++++++++++++
 tb/tb_aes_enc_iter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and round helpers.
// Used by aes_enc_iter (debug ports under AES_ENC_DBG_EN).
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } st_t;

  localparam logic [3:0] NR   = 4'd10;
  localparam byte_t      POLY = 8'h1b;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
  endfunction

  function automatic word_t mix_col(input word_t w);
    byte_t a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic block_t mix_columns(input block_t s);
    block_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  // byte k sits at row k%4, column k/4
  function automatic block_t shift_rows(input block_t s);
    block_t o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] =
          s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational.
// Indexed as one flat table, entry 0 in the top byte.
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t a,
  output byte_t y
);

  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = TBL[11'd2047 - {a, 3'b000} -: 8];

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor, one round per clock.
// Optional debug ports: define AES_ENC_DBG_EN.
module aes_enc_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
`ifdef AES_ENC_DBG_EN
  ,
  output logic [3:0]   dbg_round,
  output logic [127:0] dbg_state
`endif
);

  st_t        st, nxt;
  block_t     state_reg;
  block_t     rk_reg;
  byte_t      rcon;
  logic [3:0] round;

  block_t sb, sr, mc, state_nxt;
  block_t rk_next;
  word_t  w0, w1, w2, w3;
  word_t  rot, sub, temp;
  word_t  n0, n1, n2, n3;
  logic   take, step_ok, last;

  for (genvar i = 0; i < 16; i++) begin : g_ssb
    aes_sbox u_sb (
      .a (state_reg[127-8*i -: 8]),
      .y (sb[127-8*i -: 8])
    );
  end

  assign w0  = rk_reg[127:96];
  assign w1  = rk_reg[95:64];
  assign w2  = rk_reg[63:32];
  assign w3  = rk_reg[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_ksb
    aes_sbox u_sb (
      .a (rot[31-8*j -: 8]),
      .y (sub[31-8*j -: 8])
    );
  end

  assign temp    = sub ^ {rcon, 24'h0};
  assign n0      = w0 ^ temp;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign rk_next = {n0, n1, n2, n3};

  assign last      = (round == NR);
  assign sr        = shift_rows(sb);
  assign mc        = mix_columns(sr);
  assign state_nxt = (last ? sr : mc) ^ rk_next;

  assign in_ready  = (st == IDLE);
  assign out_valid = (st == DONE);
  assign take      = in_ready && in_valid;
  assign step_ok   = (st == RUN) &&
                     (round != 4'd0) && (round <= NR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= nxt;
  end

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE: if (in_valid) nxt = RUN;
      RUN: begin
        if (last)          nxt = DONE;
        else if (!step_ok) nxt = IDLE;
      end
      DONE: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= '0;
      rk_reg    <= '0;
      rcon      <= '0;
      round     <= '0;
      out_data  <= '0;
    end else begin
      unique case (1'b1)
        take: begin
          state_reg <= in_data ^ in_key;
          rk_reg    <= in_key;
          rcon      <= 8'h01;
          round     <= 4'd1;
        end
        step_ok: begin
          state_reg <= state_nxt;
          rk_reg    <= rk_next;
          rcon      <= xtime(rcon);
          round     <= round + 4'd1;
          if (last) out_data <= state_nxt;
        end
        default: ;
      endcase
    end
  end

`ifdef AES_ENC_DBG_EN
  assign dbg_round = round;
  assign dbg_state = state_reg;
`endif

endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed bench for aes_enc_iter: FIPS-197 vectors,
// latency, back-to-back, backpressure, mid-run reset.
module tb_aes_enc_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_data;

  int ncmp = 0;
  int nerr = 0;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_enc_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] pt,
                      input logic [127:0] key);
    in_valid = 1'b1;
    in_data  = pt;
    in_key   = key;
    step();
    in_valid = 1'b0;
    in_data  = '0;
    in_key   = '0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic run_vec(input string tag,
                         input logic [127:0] pt,
                         input logic [127:0] key,
                         input logic [127:0] ct);
    int lat;
    send(pt, key);
    chk({tag, "_busy"}, 128'(in_ready), 128'd0);
    wait_out(lat);
    chk({tag, "_lat"}, 128'(lat), 128'd10);
    chk({tag, "_ct"}, out_data, ct);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ovlo"}, 128'(out_valid), 128'd0);
    chk({tag, "_irdy"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    int lat;
    int last_pulse;
    int pulses;
    int late;
    logic prev_ov;

    step();
    step();
    chk("rst_irdy", 128'(in_ready), 128'd1);
    chk("rst_ov", 128'(out_valid), 128'd0);
    chk("rst_od", out_data, 128'd0);
    rst_n = 1'b1;
    step();

    run_vec("appb", PT_B, KEY_B, CT_B);
    run_vec("appc", PT_C, KEY_C, CT_C);
    run_vec("zero", 128'd0, 128'd0, CT_Z);

    // back-to-back zero blocks, consumer always ready
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_data    = '0;
    in_key     = '0;
    pulses     = 0;
    last_pulse = -1;
    prev_ov    = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step();
      if (out_valid) begin
        chk("b2b_ct", out_data, CT_Z);
        chk("b2b_width", 128'(prev_ov), 128'd0);
        if (last_pulse >= 0)
          chk("b2b_gap", 128'(cyc - last_pulse), 128'd12);
        last_pulse = cyc;
        pulses++;
      end
      prev_ov = out_valid;
    end
    chk("b2b_cnt", 128'(pulses), 128'd3);
    in_valid = 1'b0;
    wait_out(lat);
    step();
    out_ready = 1'b0;
    chk("b2b_idle", 128'(in_ready), 128'd1);

    // backpressure with an intruding block that must be dropped
    send(PT_C, KEY_C);
    wait_out(lat);
    chk("bp_lat", 128'(lat), 128'd10);
    in_valid = 1'b1;
    in_data  = PT_B;
    in_key   = KEY_B;
    for (int k = 0; k < 20; k++) begin
      chk("bp_ov", 128'(out_valid), 128'd1);
      chk("bp_od", out_data, CT_C);
      chk("bp_irdy", 128'(in_ready), 128'd0);
      step();
    end
    in_valid  = 1'b0;
    in_data   = '0;
    in_key    = '0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_ovlo", 128'(out_valid), 128'd0);
    chk("bp_irdy1", 128'(in_ready), 128'd1);
    late = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (out_valid || !in_ready) late++;
    end
    chk("bp_drop", 128'(late), 128'd0);

    // asynchronous reset while in round 5
    send(PT_B, KEY_B);
    for (int k = 0; k < 4; k++) step();
    chk("mid_busy", 128'(in_ready), 128'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_ov", 128'(out_valid), 128'd0);
    chk("mid_irdy", 128'(in_ready), 128'd1);
    chk("mid_od", out_data, 128'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_ov", 128'(out_valid), 128'd0);
    run_vec("post", PT_B, KEY_B, CT_B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
